// File: rtl/sar_sequencer.sv
// ---------------------------------------------------------------------------
// sar_sequencer
// Control sequencer for a successive-approximation ADC. A conversion samples
// the input for SAMPLE_CYCLES clocks, then resolves one bit per clock from the
// MSB down, using the comparator decision for each trial bit. The finished
// code is published on RESULT with a one-cycle VALID pulse. In continuous mode
// a new sample phase starts straight after each result.
//
// Parameters
//   NBITS          conversion resolution in bits (2..16)
//   SAMPLE_CYCLES  sample phase length in clocks (1..15)
//
// Ports
//   CLK       in   clock, rising-edge active
//   RST_N     in   asynchronous active-low reset
//   START     in   conversion request, only looked at while idle
//   CONT_EN   in   continuous mode, looked at in the DONE cycle
//   ABORT     in   synchronous abort back to idle, highest priority
//   COMP      in   comparator decision for the current trial bit
//   SAMPLE    out  high during the sample phase (S/H switch)
//   BUSY      out  high whenever the sequencer is not idle
//   DAC_CODE  out  trial code for the capacitive DAC
//   FLAGS     out  thermometer progress flags, filling from the MSB
//   RESULT    out  last completed conversion code
//   VALID     out  one-cycle pulse marking a new RESULT
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module sar_sequencer #(
  parameter int NBITS         = 12,
  parameter int SAMPLE_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             CONT_EN,
  input  logic             ABORT,
  input  logic             COMP,
  output logic             SAMPLE,
  output logic             BUSY,
  output logic [NBITS-1:0] DAC_CODE,
  output logic [NBITS-1:0] FLAGS,
  output logic [NBITS-1:0] RESULT,
  output logic             VALID
);

  // Bit index only ever counts from NBITS-1 down to 0.
  localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;

  localparam logic [3:0]       SAMP_LOAD = 4'(SAMPLE_CYCLES - 1);
  localparam logic [IW-1:0]    IDX_TOP   = IW'(NBITS - 1);
  localparam logic [NBITS-1:0] MSB_CODE  = {1'b1, {(NBITS-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SAMP = 2'd1,
    CONV = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [3:0]       samp_cnt;
  logic [IW-1:0]    bit_idx;
  logic [NBITS-1:0] trial_code;

  // Next-state decode. ABORT overrides every other transition.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (START) state_next = SAMP;
      SAMP:    if (samp_cnt == 4'd0) state_next = CONV;
      CONV:    if (bit_idx == '0) state_next = DONE;
      DONE:    state_next = CONT_EN ? SAMP : IDLE;
      default: state_next = IDLE;
    endcase
    if (ABORT) state_next = IDLE;
  end

  // DAC code after applying this cycle's comparator decision: the current
  // trial bit takes COMP and the next lower bit becomes the new trial bit.
  // At bit 0 this is the fully resolved conversion code.
  always_comb begin
    trial_code          = DAC_CODE;
    trial_code[bit_idx] = COMP;
    if (bit_idx != '0) trial_code[bit_idx - 1'b1] = 1'b1;
  end

  // State register, registered status decodes and the SAR datapath.
  // SAMPLE/BUSY/VALID are decoded from the next state and registered so they
  // switch cleanly together with the state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      SAMPLE   <= 1'b0;
      BUSY     <= 1'b0;
      VALID    <= 1'b0;
      DAC_CODE <= '0;
      FLAGS    <= '0;
      RESULT   <= '0;
      samp_cnt <= 4'd0;
      bit_idx  <= '0;
    end else begin
      state  <= state_next;
      SAMPLE <= (state_next == SAMP);
      BUSY   <= (state_next != IDLE);
      VALID  <= (state_next == DONE);

      if (ABORT) begin
        DAC_CODE <= '0;
        FLAGS    <= '0;
        samp_cnt <= 4'd0;
        bit_idx  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (START) begin
              DAC_CODE <= '0;
              FLAGS    <= '0;
              samp_cnt <= SAMP_LOAD;
            end
          end
          SAMP: begin
            if (samp_cnt == 4'd0) begin
              DAC_CODE <= MSB_CODE;
              bit_idx  <= IDX_TOP;
            end else begin
              samp_cnt <= samp_cnt - 4'd1;
            end
          end
          CONV: begin
            DAC_CODE       <= trial_code;
            FLAGS[bit_idx] <= 1'b1;
            if (bit_idx == '0) RESULT  <= trial_code;
            else               bit_idx <= bit_idx - 1'b1;
          end
          DONE: begin
            if (CONT_EN) begin
              DAC_CODE <= '0;
              FLAGS    <= '0;
              samp_cnt <= SAMP_LOAD;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sar_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sar_sequencer
// Directed self-checking bench for sar_sequencer. One instance runs at the
// default parameters (12 bits, 2 sample cycles); a second, small instance
// runs with NBITS=4 and SAMPLE_CYCLES=1. Inputs change and outputs are read
// on the falling clock edge, so observation n after a request is the state
// following rising edge E0+n.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_sar_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start, cont_en, abort, comp;
  logic        sample, busy, valid;
  logic [11:0] dac_code, flags, result;

  logic        s_start, s_cont_en, s_abort, s_comp;
  logic        s_sample, s_busy, s_valid;
  logic [3:0]  s_dac_code, s_flags, s_result;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [11:0] dac_trace   [0:63];
  logic [11:0] flags_trace [0:63];
  logic        valid_trace [0:63];
  logic        busy_trace  [0:63];
  int          first_valid;
  int          valid_count;
  int          sample_hi;
  int          busy_drops;

  sar_sequencer #(.NBITS(12), .SAMPLE_CYCLES(2)) dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .CONT_EN(cont_en),
    .ABORT(abort), .COMP(comp), .SAMPLE(sample), .BUSY(busy),
    .DAC_CODE(dac_code), .FLAGS(flags), .RESULT(result), .VALID(valid)
  );

  sar_sequencer #(.NBITS(4), .SAMPLE_CYCLES(1)) dut_small (
    .CLK(clk), .RST_N(rst_n), .START(s_start), .CONT_EN(s_cont_en),
    .ABORT(s_abort), .COMP(s_comp), .SAMPLE(s_sample), .BUSY(s_busy),
    .DAC_CODE(s_dac_code), .FLAGS(s_flags), .RESULT(s_result), .VALID(s_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Issue a START on the 12-bit instance and watch n_max cycles. COMP is fed
  // from bits MSB-first during each conversion window (15-cycle period).
  // ABORT is pulsed in cycle abort_at, CONT_EN is dropped in cycle cont_stop.
  task automatic applyStimulus(input logic [11:0] bits, input int abort_at,
                               input int cont_stop, input int n_max);
    int p;
    start = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    first_valid = -1;
    valid_count = 0;
    sample_hi   = 0;
    busy_drops  = 0;
    for (int n = 0; n < n_max; n++) begin
      dac_trace[n]   = dac_code;
      flags_trace[n] = flags;
      valid_trace[n] = valid;
      busy_trace[n]  = busy;
      if (sample) sample_hi++;
      if (!busy) busy_drops++;
      if (valid) begin
        valid_count++;
        if (first_valid < 0) first_valid = n;
      end
      p     = n % 15;
      comp  = (p >= 2 && p <= 13) ? bits[13 - p] : 1'b0;
      abort = (n == abort_at);
      if (n == cont_stop) cont_en = 1'b0;
      @(negedge clk);
    end
    abort = 1'b0;
    comp  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; cont_en = 1'b0; abort = 1'b0; comp = 1'b0;
    s_start = 1'b0; s_cont_en = 1'b0; s_abort = 1'b0; s_comp = 1'b0;

    #2;
    checkOutput("reset_busy",   {31'd0, busy},   32'd0);
    checkOutput("reset_sample", {31'd0, sample}, 32'd0);
    checkOutput("reset_result", {20'd0, result}, 32'd0);
    checkOutput("reset_flags",  {20'd0, flags},  32'd0);
    checkOutput("reset_dac",    {20'd0, dac_code}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // COMP held high: full-scale code, two sample cycles, VALID at E0+14.
    applyStimulus(12'hFFF, -1, -1, 17);
    checkOutput("ones_sample_cycles", sample_hi, 2);
    checkOutput("ones_valid_at",      first_valid, 14);
    checkOutput("ones_valid_count",   valid_count, 1);
    checkOutput("ones_result",        {20'd0, result}, 32'hFFF);
    checkOutput("ones_flags_done",    {20'd0, flags_trace[14]}, 32'hFFF);
    checkOutput("ones_flags_idle",    {20'd0, flags}, 32'hFFF);
    checkOutput("ones_busy_idle",     {31'd0, busy}, 32'd0);

    // Mixed decisions: check the DAC trial walk and the resolved code.
    applyStimulus(12'hA5C, -1, -1, 17);
    checkOutput("walk_flags_cleared", {20'd0, flags_trace[0]}, 32'h000);
    checkOutput("walk_dac_n2", {20'd0, dac_trace[2]}, 32'h800);
    checkOutput("walk_dac_n3", {20'd0, dac_trace[3]}, 32'hC00);
    checkOutput("walk_dac_n4", {20'd0, dac_trace[4]}, 32'hA00);
    checkOutput("walk_dac_n5", {20'd0, dac_trace[5]}, 32'hB00);
    checkOutput("walk_dac_n6", {20'd0, dac_trace[6]}, 32'hA80);
    checkOutput("walk_flags_n7", {20'd0, flags_trace[7]}, 32'hF80);
    checkOutput("walk_dac_done", {20'd0, dac_trace[14]}, 32'hA5C);
    checkOutput("walk_valid_at", first_valid, 14);
    checkOutput("walk_result",   {20'd0, result}, 32'hA5C);

    // ABORT in the fifth CONV cycle: idle next edge, RESULT untouched.
    applyStimulus(12'h3C3, 6, -1, 20);
    checkOutput("abort_busy_before", {31'd0, busy_trace[6]}, 32'd1);
    checkOutput("abort_busy_after",  {31'd0, busy_trace[7]}, 32'd0);
    checkOutput("abort_flags",       {20'd0, flags_trace[7]}, 32'h000);
    checkOutput("abort_dac",         {20'd0, dac_trace[7]}, 32'h000);
    checkOutput("abort_no_valid",    valid_count, 0);
    checkOutput("abort_result_kept", {20'd0, result}, 32'hA5C);

    // Reset pulsed mid-SAMP, away from any rising edge.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("pre_reset_sample", {31'd0, sample}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_sample", {31'd0, sample}, 32'd0);
    checkOutput("async_rst_busy",   {31'd0, busy},   32'd0);
    checkOutput("async_rst_result", {20'd0, result}, 32'd0);
    checkOutput("async_rst_valid",  {31'd0, valid},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_idle", {31'd0, busy}, 32'd0);
    applyStimulus(12'h3C5, -1, -1, 16);
    checkOutput("post_rst_valid_at", first_valid, 14);
    checkOutput("post_rst_result",   {20'd0, result}, 32'h3C5);

    // Continuous mode, COMP low: VALID every 15 cycles, BUSY never drops.
    cont_en = 1'b1;
    applyStimulus(12'h000, -1, 44, 47);
    checkOutput("cont_valid_at",    first_valid, 14);
    checkOutput("cont_valid_29",    {31'd0, valid_trace[29]}, 32'd1);
    checkOutput("cont_valid_44",    {31'd0, valid_trace[44]}, 32'd1);
    checkOutput("cont_valid_count", valid_count, 3);
    checkOutput("cont_busy_drops",  busy_drops - (busy_trace[45] ? 0 : 1) - (busy_trace[46] ? 0 : 1), 0);
    checkOutput("cont_stop_idle",   {31'd0, busy_trace[45]}, 32'd0);
    checkOutput("cont_result",      {20'd0, result}, 32'h000);

    // Small instance: 4 bits, 1 sample cycle, COMP 1,1,0,1, extra START ignored.
    begin
      int sv_first;
      int sv_count;
      logic [3:0] s_bits;
      s_bits   = 4'hD;
      sv_first = -1;
      sv_count = 0;
      s_start  = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      for (int n = 0; n < 8; n++) begin
        if (s_valid) begin
          sv_count++;
          if (sv_first < 0) sv_first = n;
        end
        s_comp  = (n >= 1 && n <= 4) ? s_bits[4 - n] : 1'b0;
        s_start = (n == 2);
        @(negedge clk);
      end
      s_start = 1'b0;
      s_comp  = 1'b0;
      checkOutput("small_valid_at",    sv_first, 5);
      checkOutput("small_valid_count", sv_count, 1);
      checkOutput("small_result",      {28'd0, s_result}, 32'hD);
      checkOutput("small_flags",       {28'd0, s_flags}, 32'hF);
      checkOutput("small_idle",        {31'd0, s_busy}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sar_sequencer.md
SAR_SEQUENCER -- requirements
Module: sar_sequencer

Interface
REQ-001 Parameter NBITS, default 12: conversion resolution in bits; legal range 2..16.
REQ-002 Parameter SAMPLE_CYCLES, default 2: length of the sample phase in clock cycles; legal range 1..15.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RST_N  input  1  reset, asynchronous assertion, active-low.
REQ-005 START  input  1  conversion request; sampled only in IDLE.
REQ-006 CONT_EN  input  1  continuous mode: 1 = restart the sample phase automatically after each conversion.
REQ-007 ABORT  input  1  synchronous abort; forces IDLE on the next edge.
REQ-008 COMP  input  1  comparator decision for the current trial bit: 1 = keep bit, 0 = clear bit.
REQ-009 SAMPLE  output  1  high while in the SAMPLE state (drives the S/H switch).
REQ-010 BUSY  output  1  high in every state except IDLE.
REQ-011 DAC_CODE  output  NBITS  trial code presented to the capacitive DAC.
REQ-012 FLAGS  output  NBITS  thermometer progress flags, filling from the MSB.
REQ-013 RESULT  output  NBITS  last completed conversion code.
REQ-014 VALID  output  1  one-cycle pulse marking a new RESULT.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, SAMP, CONV and DONE.
REQ-016 IDLE: START=1 and ABORT=0 at an edge -> SAMP; otherwise stay in IDLE. START in any other state SHALL be ignored.
REQ-017 On entry to SAMP: DAC_CODE and FLAGS SHALL clear to 0 and the sample counter SHALL load SAMPLE_CYCLES-1.
REQ-018 SAMP SHALL last exactly SAMPLE_CYCLES cycles, then go to CONV with DAC_CODE = 1 << (NBITS-1) and bit index i = NBITS-1.
REQ-019 CONV, each edge at bit index i:
 - DAC_CODE[i] <= COMP
 - if i>0: DAC_CODE[i-1] <= 1, and i decrements
 - FLAGS[i] <= 1
REQ-020 CONV SHALL last exactly NBITS cycles; the edge that resolves i=0 SHALL go to DONE.
REQ-021 On the edge that enters DONE, RESULT SHALL load the fully resolved code; VALID SHALL be 1 only during the DONE cycle.
REQ-022 DONE SHALL last one cycle, then go to SAMP if CONT_EN=1, else to IDLE; CONT_EN is sampled in DONE only.
REQ-023 Latency: START sampled at edge E0 -> VALID high in the cycle after edge E0+SAMPLE_CYCLES+NBITS (14 edges at the defaults).
REQ-024 FLAGS SHALL equal all-ones in DONE and SHALL hold that value in IDLE until the next SAMP entry.
REQ-025 RESULT SHALL hold its value until the next DONE; ABORT SHALL never modify RESULT.
REQ-026 ABORT=1 at any edge SHALL force IDLE with no VALID pulse, DAC_CODE=0 and FLAGS=0; ABORT takes priority over START and CONT_EN.
REQ-027 SAMPLE and BUSY SHALL be registered, glitch-free decodes of the state register.
REQ-028 Arithmetic: the bit index and sample counter SHALL be sized for their parameter ranges and SHALL never wrap below 0.

Reset
REQ-029 RST_N=0 SHALL asynchronously force: state IDLE, SAMPLE=0, BUSY=0, DAC_CODE=0, FLAGS=0, RESULT=0, VALID=0, and clear all counters.
REQ-030 Reset asserted mid-conversion SHALL discard the conversion with no VALID pulse; the first START after RST_N=1 SHALL begin a full conversion.

Verification
REQ-031 Defaults, COMP held 1, START pulse at edge E0 -> SAMPLE high for 2 cycles, VALID at E0+14, RESULT=0xFFF, FLAGS=0xFFF.
REQ-032 Defaults, COMP sequence MSB-first 1,0,1,0,0,1,0,1,1,1,0,0 -> RESULT=0xA5C and DAC_CODE walks 0x800, 0xC00, 0xA00, ...
REQ-033 COMP held 0 with CONT_EN=1 -> RESULT=0x000, VALID pulses every 15 cycles, BUSY never drops between conversions.
REQ-034 ABORT asserted in the 5th CONV cycle -> IDLE next edge, no VALID, RESULT keeps its previous value, FLAGS=0.
REQ-035 RST_N pulsed low mid-SAMP -> all outputs 0 immediately, with no dependence on CLK.
REQ-036 NBITS=4, SAMPLE_CYCLES=1, COMP=1,1,0,1 -> RESULT=0xD, VALID at E0+5; START repeated while BUSY is ignored.
